// File: rtl/davgen_pkg.sv
// Shared types and helpers for the programmable DAV generator.
package davgen_pkg;

    // Generator state; prefixed to stay clear of the GAP parameter name.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    // Map a requested latency onto the legal range 1..max_dly.
    function automatic int unsigned clamp_dly(input int unsigned cfg,
                                              input int unsigned max_dly);
        if (cfg == 0) begin
            return 1;
        end else if (cfg > max_dly) begin
            return max_dly;
        end else begin
            return cfg;
        end
    endfunction

endpackage

// File: rtl/davgen_dline.sv
// L1A delay line: shift register with a selectable tap and synchronous flush.
module davgen_dline #(
    parameter int unsigned DEPTH = 31,
    parameter int unsigned SW    = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          din,
    input  logic [SW-1:0] sel,
    output logic          tap
);

    logic [DEPTH-1:0] line;

    // Shift one stage per clock; reset and flush both empty the line.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            line <= '0;
        end else begin
            line <= DEPTH'({line, din});
        end
    end

    // Tap stage sel-1, so sel counts clocks of delay.
    always_comb begin
        tap = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (32'(sel) == i + 1) begin
                tap = line[i];
            end
        end
    end

endmodule

// File: rtl/davgen_prog.sv
// Data-available generator: delays L1A by a programmable latency and emits
// DAV pulses of fixed width and minimum spacing, queueing overlapping events.
module davgen_prog
    import davgen_pkg::*;
#(
    parameter int unsigned MAX_DLY     = 31,
    parameter int unsigned DW          = 5,
    parameter int unsigned DLY_DEFAULT = 11,
    parameter int unsigned DAV_W       = 1,
    parameter int unsigned GAP         = 0,
    parameter int unsigned PEND_MAX    = 7,
    parameter int unsigned PW          = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          l1a,
    input  logic          dly_ld,
    input  logic [DW-1:0] dly_cfg,
    output logic          davalid,
    output logic          busy,
    output logic [PW-1:0] pending,
    output logic          ovf
);

    localparam int unsigned CNT_MAX = (DAV_W > GAP) ? DAV_W : GAP;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [DW-1:0] dly_r;
    logic          ev;
    logic          ev_v;
    logic          avail;
    logic          done;
    logic          start;
    logic          inc;
    logic          dec;

    davgen_dline #(
        .DEPTH (MAX_DLY),
        .SW    (DW)
    ) u_dline (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (dly_ld),
        .din   (l1a),
        .sel   (dly_r),
        .tap   (ev)
    );

    // Event availability and pulse-start decode; a load cycle sees no events.
    always_comb begin
        ev_v  = ev & ~dly_ld;
        avail = ev_v | ((pending != '0) & ~dly_ld);
        done  = (cnt == '0);
        start = 1'b0;
        case (state)
            S_IDLE:  start = avail;
            S_PULSE: start = done && (GAP == 0) && avail;
            S_GAP:   start = done && avail;
            default: start = 1'b0;
        endcase
        inc = ev_v & ~start;
        dec = start & ~ev_v;
    end

    // Pulse FSM with registered davalid/busy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            davalid <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (avail) begin
                        state   <= S_PULSE;
                        davalid <= 1'b1;
                        busy    <= 1'b1;
                        cnt     <= CW'(DAV_W - 1);
                    end
                end
                S_PULSE: begin
                    if (!done) begin
                        cnt <= cnt - CW'(1);
                    end else if (GAP > 0) begin
                        state   <= S_GAP;
                        davalid <= 1'b0;
                        cnt     <= CW'(GAP - 1);
                    end else if (avail) begin
                        cnt <= CW'(DAV_W - 1);
                    end else begin
                        state   <= S_IDLE;
                        davalid <= 1'b0;
                        busy    <= 1'b0;
                    end
                end
                S_GAP: begin
                    if (!done) begin
                        cnt <= cnt - CW'(1);
                    end else if (avail) begin
                        state   <= S_PULSE;
                        davalid <= 1'b1;
                        cnt     <= CW'(DAV_W - 1);
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    davalid <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    // Latency register, saturating pending-event counter and sticky overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dly_r   <= DW'(DLY_DEFAULT);
            pending <= '0;
            ovf     <= 1'b0;
        end else if (dly_ld) begin
            dly_r   <= DW'(clamp_dly(32'(dly_cfg), MAX_DLY));
            pending <= '0;
            ovf     <= 1'b0;
        end else if (inc && !dec) begin
            if (pending == PW'(PEND_MAX)) begin
                ovf <= 1'b1;
            end else begin
                pending <= pending + PW'(1);
            end
        end else if (dec && !inc) begin
            pending <= pending - PW'(1);
        end
    end

endmodule

// File: tb/tb_davgen_prog.sv
// Directed bench for davgen_prog: three instances cover the legacy configuration,
// a wide-pulse/gap configuration and a reduced maximum latency.
module tb_davgen_prog;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance A: defaults (DAV_W=1, GAP=0, MAX_DLY=31)
    logic       rst_a, la, ld_a, dav_a, busy_a, ovf_a;
    logic [4:0] cfg_a;
    logic [2:0] pend_a;
    // Instance B: DAV_W=4, GAP=2
    logic       rst_b, lb, ld_b, dav_b, busy_b, ovf_b;
    logic [4:0] cfg_b;
    logic [2:0] pend_b;
    // Instance C: MAX_DLY=20
    logic       rst_c, lc, ld_c, dav_c, busy_c, ovf_c;
    logic [4:0] cfg_c;
    logic [2:0] pend_c;

    davgen_prog u_a (
        .clk(clk), .rst_n(rst_a), .l1a(la), .dly_ld(ld_a), .dly_cfg(cfg_a),
        .davalid(dav_a), .busy(busy_a), .pending(pend_a), .ovf(ovf_a)
    );

    davgen_prog #(.DAV_W(4), .GAP(2)) u_b (
        .clk(clk), .rst_n(rst_b), .l1a(lb), .dly_ld(ld_b), .dly_cfg(cfg_b),
        .davalid(dav_b), .busy(busy_b), .pending(pend_b), .ovf(ovf_b)
    );

    davgen_prog #(.MAX_DLY(20), .DW(5)) u_c (
        .clk(clk), .rst_n(rst_c), .l1a(lc), .dly_ld(ld_c), .dly_cfg(cfg_c),
        .davalid(dav_c), .busy(busy_c), .pending(pend_c), .ovf(ovf_c)
    );

    // Advance past one rising edge; outputs read afterwards reflect that edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        la = 1'b1; lb = 1'b1; lc = 1'b1;
        step();
        step();
        la = 1'b0; lb = 1'b0; lc = 1'b0;
        checks++;
        if ({dav_a, busy_a, pend_a, ovf_a} !== 6'b0) begin
            failures++;
            $display("FAIL reset_a got=%b exp=000000", {dav_a, busy_a, pend_a, ovf_a});
        end
        checks++;
        if ({dav_b, busy_b, pend_b, ovf_b} !== 6'b0) begin
            failures++;
            $display("FAIL reset_b got=%b exp=000000", {dav_b, busy_b, pend_b, ovf_b});
        end
        checks++;
        if ({dav_c, busy_c, pend_c, ovf_c} !== 6'b0) begin
            failures++;
            $display("FAIL reset_c got=%b exp=000000", {dav_c, busy_c, pend_c, ovf_c});
        end
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    endtask

    // Default latency 11: l1a at edge 5 gives a single DAV clock after edge 16.
    task automatic test_default_latency();
        logic [39:0] got;
        logic [39:0] bsy;
        got = '0;
        bsy = '0;
        for (int c = 0; c < 40; c++) begin
            la = (c == 5);
            step();
            got[c] = dav_a;
            bsy[c] = busy_a;
        end
        la = 1'b0;
        checks++;
        if (got !== (40'd1 << 16)) begin
            failures++;
            $display("FAIL default_latency got=%h exp=%h", got, 40'd1 << 16);
        end
        checks++;
        if (bsy !== (40'd1 << 16)) begin
            failures++;
            $display("FAIL default_busy got=%h exp=%h", bsy, 40'd1 << 16);
        end
    endtask

    // Latency 3, four consecutive L1As: continuous 4-clock DAV, nothing queued.
    task automatic test_back_to_back();
        logic [19:0] got;
        logic [2:0]  pmax;
        got  = '0;
        pmax = '0;
        cfg_a = 5'd3;
        ld_a  = 1'b1;
        step();
        ld_a = 1'b0;
        for (int c = 0; c < 20; c++) begin
            la = (c < 4);
            step();
            got[c] = dav_a;
            if (pend_a > pmax) pmax = pend_a;
        end
        la = 1'b0;
        checks++;
        if (got !== 20'h00078) begin
            failures++;
            $display("FAIL back_to_back got=%h exp=00078", got);
        end
        checks++;
        if (pmax !== 3'd0) begin
            failures++;
            $display("FAIL b2b_pending got=%0d exp=0", pmax);
        end
    endtask

    // Latency 5, DAV_W=4, GAP=2: L1As at 0,1,2 give pulses after edges 5, 11, 17.
    task automatic test_pulse_gap();
        logic [29:0] got;
        logic [29:0] bsy;
        logic [2:0]  pmax;
        got  = '0;
        bsy  = '0;
        pmax = '0;
        cfg_b = 5'd5;
        ld_b  = 1'b1;
        step();
        ld_b = 1'b0;
        for (int c = 0; c < 30; c++) begin
            lb = (c < 3);
            step();
            got[c] = dav_b;
            bsy[c] = busy_b;
            if (pend_b > pmax) pmax = pend_b;
        end
        lb = 1'b0;
        checks++;
        if (got !== 30'h001E79E0) begin
            failures++;
            $display("FAIL pulse_gap_dav got=%h exp=001e79e0", got);
        end
        checks++;
        if (bsy !== 30'h007FFFE0) begin
            failures++;
            $display("FAIL pulse_gap_busy got=%h exp=007fffe0", bsy);
        end
        checks++;
        if (pmax !== 3'd2) begin
            failures++;
            $display("FAIL pulse_gap_pending_peak got=%0d exp=2", pmax);
        end
    endtask

    // 12 back-to-back L1As: pulse at the first event, the event meeting the
    // second slot is consumed directly, 7 queued, 3 dropped -> 9 pulses.
    task automatic test_overflow();
        int         pulses;
        logic       prev;
        logic [2:0] pmax;
        logic [2:0] p16;
        logic       o16;
        pulses = 0;
        prev   = 1'b0;
        pmax   = '0;
        p16    = '0;
        o16    = 1'b0;
        for (int c = 0; c < 80; c++) begin
            lb = (c < 12);
            step();
            if (dav_b && !prev) pulses++;
            prev = dav_b;
            if (pend_b > pmax) pmax = pend_b;
            if (c == 16) begin
                p16 = pend_b;
                o16 = ovf_b;
            end
        end
        lb = 1'b0;
        checks++;
        if (pulses != 9) begin
            failures++;
            $display("FAIL ovf_pulse_count got=%0d exp=9", pulses);
        end
        checks++;
        if (pmax !== 3'd7) begin
            failures++;
            $display("FAIL ovf_pending_peak got=%0d exp=7", pmax);
        end
        checks++;
        if ({p16, o16} !== {3'd7, 1'b1}) begin
            failures++;
            $display("FAIL ovf_saturate got=pending %0d ovf %b exp=pending 7 ovf 1", p16, o16);
        end
        checks++;
        if ({pend_b, busy_b, ovf_b} !== {3'd0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL ovf_drained got=pending %0d busy %b ovf %b exp=pending 0 busy 0 ovf 1",
                     pend_b, busy_b, ovf_b);
        end
    endtask

    // Load during a pulse with 3 queued: pulse finishes, queue, ovf and line cleared.
    task automatic test_flush();
        logic [29:0] got;
        logic [2:0]  p8;
        logic [3:0]  after_ld;
        got      = '0;
        p8       = '0;
        after_ld = '1;
        cfg_b    = 5'd5;
        for (int c = 0; c < 30; c++) begin
            lb   = (c < 4) || (c == 6);
            ld_b = (c == 9);
            step();
            got[c] = dav_b;
            if (c == 8) p8 = pend_b;
            if (c == 9) after_ld = {pend_b, ovf_b};
        end
        lb   = 1'b0;
        ld_b = 1'b0;
        checks++;
        if (p8 !== 3'd3) begin
            failures++;
            $display("FAIL flush_pending_before got=%0d exp=3", p8);
        end
        checks++;
        if (after_ld !== 4'b0000) begin
            failures++;
            $display("FAIL flush_cleared got=%b exp=0000", after_ld);
        end
        checks++;
        if (got !== 30'h000001E0) begin
            failures++;
            $display("FAIL flush_dav got=%h exp=000001e0", got);
        end
    endtask

    // Reset mid-pulse clears outputs and restores the default latency of 11.
    task automatic test_reset_mid();
        logic [19:0] got;
        got = '0;
        for (int c = 0; c < 7; c++) begin
            lb = (c < 3);
            step();
        end
        lb = 1'b0;
        checks++;
        if ({dav_b, pend_b} !== {1'b1, 3'd1}) begin
            failures++;
            $display("FAIL rst_mid_pre got=dav %b pending %0d exp=dav 1 pending 1", dav_b, pend_b);
        end
        rst_b = 1'b0;
        step();
        rst_b = 1'b1;
        checks++;
        if ({dav_b, busy_b, pend_b, ovf_b} !== 6'b0) begin
            failures++;
            $display("FAIL rst_mid got=%b exp=000000", {dav_b, busy_b, pend_b, ovf_b});
        end
        for (int c = 0; c < 20; c++) begin
            lb = (c == 0);
            step();
            got[c] = dav_b;
        end
        lb = 1'b0;
        checks++;
        if (got !== 20'h07800) begin
            failures++;
            $display("FAIL rst_mid_latency got=%h exp=07800", got);
        end
    endtask

    // dly_cfg=0 behaves as latency 1; 31 clamps to MAX_DLY=20.
    task automatic test_clamp();
        logic [9:0]  g0;
        logic [29:0] g31;
        g0  = '0;
        g31 = '0;
        cfg_c = 5'd0;
        ld_c  = 1'b1;
        step();
        ld_c = 1'b0;
        for (int c = 0; c < 10; c++) begin
            lc = (c == 0);
            step();
            g0[c] = dav_c;
        end
        lc = 1'b0;
        checks++;
        if (g0 !== 10'h002) begin
            failures++;
            $display("FAIL clamp_zero got=%h exp=002", g0);
        end
        cfg_c = 5'd31;
        ld_c  = 1'b1;
        step();
        ld_c = 1'b0;
        for (int c = 0; c < 30; c++) begin
            lc = (c == 0);
            step();
            g31[c] = dav_c;
        end
        lc = 1'b0;
        checks++;
        if (g31 !== (30'd1 << 20)) begin
            failures++;
            $display("FAIL clamp_max got=%h exp=%h", g31, 30'd1 << 20);
        end
    endtask

    initial begin
        la = 1'b0; ld_a = 1'b0; cfg_a = '0;
        lb = 1'b0; ld_b = 1'b0; cfg_b = '0;
        lc = 1'b0; ld_c = 1'b0; cfg_c = '0;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        test_reset();
        test_default_latency();
        test_back_to_back();
        test_pulse_gap();
        test_overflow();
        test_flush();
        test_reset_mid();
        test_clamp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
